// File: rtl/uart_rx_deserializer.sv
// UART receiver: 8N1 frames, mid-bit sampling, one-entry valid/ready output buffer.
// Flags framing errors and overruns as single-cycle pulses.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state, next_state;
    logic             s_meta, s_sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             sample_bit, commit, frame_bad, idx_clr;

    // Handshake: a byte moves to the consumer on any rising edge where
    // data_valid and data_ready are both high; data_out is stable while valid.

    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta <= 1'b1;
            s_sync <= 1'b1;
        end else begin
            s_meta <= s_in;
            s_sync <= s_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        sample_bit = 1'b0;
        commit     = 1'b0;
        frame_bad  = 1'b0;
        idx_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (!s_sync) next_state = START;
            end
            START: begin
                // A start bit that is gone by its centre was noise; drop silently.
                if (cnt == HALF_LAST) begin
                    if (!s_sync) begin
                        next_state = DATA;
                        idx_clr    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    sample_bit = 1'b1;
                    if (idx == 3'd7) next_state = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    if (s_sync) begin
                        commit     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        next_state = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (s_sync) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counter restarts on every state change and at each data-bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state || sample_bit) begin
            cnt <= '0;
        end else if (state == START || state == DATA || state == STOP) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= 3'd0;
            shreg <= 8'h00;
        end else begin
            if (idx_clr) idx <= 3'd0;
            else if (sample_bit && idx != 3'd7) idx <= idx + 3'd1;
            if (sample_bit) shreg <= {s_sync, shreg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= 1'b0;
            if (commit) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: directed scenarios plus random frames,
// scoreboarded against bytes predicted from the frames the bench puts on the line.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         rdy_mode = 1;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (s_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // consumer: 0 = never ready, 1 = always ready, 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       data_ready = 1'b0;
                1:       data_ready = 1'b1;
                default: data_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every accepted byte and polices the flag pulses
    task automatic monitor();
        logic fe_prev = 1'b0;
        logic ov_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fe_prev = 1'b0;
                ov_prev = 1'b0;
            end else begin
                if (data_valid && data_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
                    end else begin
                        check("rx_byte", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
                    end
                end
                if (frame_err || overrun) begin
                    check("flags_exclusive", {31'h0, frame_err & overrun}, 32'h0);
                    check("flag_one_cycle", {31'h0, (frame_err & fe_prev) | (overrun & ov_prev)}, 32'h0);
                end
                if (frame_err) fe_cnt++;
                if (overrun)   ov_cnt++;
                fe_prev = frame_err;
                ov_prev = overrun;
            end
        end
    endtask

    // driver tasks: all line changes happen 1ns after a rising edge
    task automatic drive(input logic v, input int n);
        s_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop_bit, CPB);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data_out"}, {24'h0, data_out}, 32'h0);
        check({tag, "_data_valid"}, {31'h0, data_valid}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
        check({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
    endtask

    initial begin
        rst  = 1'b1;
        s_in = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        drive(1'b1, 5);

        // 1: single byte, consumer always ready
        rdy_mode = 1;
        send_good(8'hA5);
        drive(1'b1, 4);
        wait_drain("t1_drain");
        check("t1_valid_low", {31'h0, data_valid}, 32'h0);
        check("t1_fe", fe_cnt, exp_fe);

        // 2: two back-to-back bytes with consumer stalled -> overrun on the second
        rdy_mode = 0;
        drive(1'b1, 3);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("t2_valid_held", {31'h0, data_valid}, 32'h1);
        check("t2_first_byte", {24'h0, data_out}, 32'h3C);
        send_frame(8'hC3, 1'b1);
        exp_ov++;
        drive(1'b1, 3);
        check("t2_overrun", ov_cnt, exp_ov);
        check("t2_byte_kept", {24'h0, data_out}, 32'h3C);
        check("t2_valid_still", {31'h0, data_valid}, 32'h1);
        rdy_mode = 1;
        wait_drain("t2_drain");

        // 3: framing error, line held low, then recovery
        drive(1'b1, 5);
        send_frame(8'h55, 1'b0);
        exp_fe++;
        drive(1'b0, 40);
        check("t3_busy_low_line", {31'h0, busy}, 32'h1);
        check("t3_no_valid", {31'h0, data_valid}, 32'h0);
        check("t3_frame_err", fe_cnt, exp_fe);
        drive(1'b1, 6);
        check("t3_idle_again", {31'h0, busy}, 32'h0);
        send_good(8'h0F);
        drive(1'b1, 4);
        wait_drain("t3_drain");

        // 4: short glitch must not start a frame
        drive(1'b0, 4);
        drive(1'b1, 30);
        check("t4_busy", {31'h0, busy}, 32'h0);
        check("t4_valid", {31'h0, data_valid}, 32'h0);
        check("t4_fe", fe_cnt, exp_fe);
        check("t4_ov", ov_cnt, exp_ov);

        // 5: reset in the middle of a frame
        drive(1'b0, CPB);
        drive(1'b1, 3 * CPB);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("t5_reset");
        rst = 1'b0;
        drive(1'b1, 20);
        send_good(8'h81);
        drive(1'b1, 4);
        wait_drain("t5_drain");

        // 6: loopback-style extremes, back-to-back
        send_good(8'h00);
        send_good(8'hFF);
        drive(1'b1, 4);
        wait_drain("t6_drain");

        // random bytes, random consumer, random idle gaps
        rdy_mode = 2;
        for (int k = 0; k < 20; k++) begin
            send_good(8'($urandom_range(0, 255)));
            drive(1'b1, $urandom_range(0, 20));
        end
        rdy_mode = 1;
        drive(1'b1, 4);
        wait_drain("rand_drain");

        check("final_fe", fe_cnt, exp_fe);
        check("final_ov", ov_cnt, exp_ov);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
